// File: rtl/oam_dma_ctrl.sv
// Purpose: OAM DMA engine (FF46); copies 160 bytes from page S:00..S:9F into OAM 00..9F.
// Latency: FF46 write -> first XFER cycle 5 cycles later, then 4 cycles per byte (640 cycles).
// Backpressure: none; the source bus is assumed to return dma_din in time, and the FSM free-runs.
// Ports: cclk/n_reset2 clock and async active-low reset; ff46_wr/ff46_rd/d_in/d_out CPU FF46 access;
//   dma_din source byte; dma_pending/dma_run/dma_a/dma_a_hi/vram_to_oam/dma_addr_ext source-side
//   control to PPU and arbiter; oam_a/oam_din/oam_dma_wr OAM write port.
module oam_dma_ctrl (
  input  logic        cclk,
  input  logic        n_reset2,
  input  logic        ff46_wr,
  input  logic        ff46_rd,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  input  logic [7:0]  dma_din,
  output logic        dma_pending,
  output logic        dma_run,
  output logic [12:0] dma_a,
  output logic [2:0]  dma_a_hi,
  output logic        vram_to_oam,
  output logic        dma_addr_ext,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_din,
  output logic        oam_dma_wr
);

  localparam logic [7:0] LAST_CNT = 8'd159;  // LEN-1
  localparam logic [1:0] PH_LATCH = 2'd2;    // CYC-2
  localparam logic [1:0] PH_WR    = 2'd3;    // CYC-1
  localparam logic [3:0] DLY_LAST = 4'd3;    // START_DLY*CYC-1

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  s_q, s_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  dly_q, dly_d;
  logic [7:0]  din_q, din_d;
  logic        wr_q, wr_d;
  // Set when START was entered from XFER, so OAM ownership is not released across a restart.
  logic        run_q, run_d;

  always_ff @(posedge cclk or negedge n_reset2) begin
    if (!n_reset2) begin
      state_q <= IDLE;
      s_q     <= 8'h00;
      cnt_q   <= 8'h00;
      phase_q <= 2'd0;
      dly_q   <= 4'd0;
      din_q   <= 8'h00;
      wr_q    <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      dly_q   <= dly_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      run_q   <= run_d;
    end
  end

  // The page is captured on the write edge; the FSM acts on the registered strobe one cycle
  // later, which places the first XFER cycle five cycles after the write.
  always_comb begin
    state_d    = state_q;
    s_d        = ff46_wr ? d_in : s_q;
    wr_d       = ff46_wr;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    dly_d      = dly_q;
    din_d      = din_q;
    run_d      = run_q;
    oam_dma_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_q) begin
          state_d = START;
          dly_d   = 4'd0;
          run_d   = 1'b0;
        end
      end
      START: begin
        if (wr_q) begin
          dly_d = 4'd0;
        end else if (dly_q == DLY_LAST) begin
          state_d = XFER;
          cnt_d   = 8'h00;
          phase_d = 2'd0;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      XFER: begin
        // The write pulse of the current byte still goes out even if a restart lands here.
        oam_dma_wr = (phase_q == PH_WR);
        if (phase_q == PH_LATCH) din_d = dma_din;
        if (wr_q) begin
          state_d = START;
          dly_d   = 4'd0;
          run_d   = 1'b1;
          cnt_d   = 8'h00;
          phase_d = 2'd0;
        end else if (phase_q == PH_WR) begin
          phase_d = 2'd0;
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
            cnt_d   = 8'h00;
            run_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dma_run      = (state_q == XFER) || ((state_q == START) && run_q);
  assign dma_pending  = (state_q == START) && !run_q;
  assign dma_a        = {s_q[4:0], cnt_q};
  assign dma_a_hi     = s_q[7:5];
  assign vram_to_oam  = (s_q[7:5] == 3'b100);
  assign dma_addr_ext = dma_run && !vram_to_oam;
  assign oam_a        = cnt_q;
  assign oam_din      = din_q;
  assign d_out        = ff46_rd ? s_q : 8'h00;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  logic        cclk;
  logic        n_reset2;
  logic        ff46_wr;
  logic        ff46_rd;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic [7:0]  dma_din;
  logic        dma_pending;
  logic        dma_run;
  logic [12:0] dma_a;
  logic [2:0]  dma_a_hi;
  logic        vram_to_oam;
  logic        dma_addr_ext;
  logic [7:0]  oam_a;
  logic [7:0]  oam_din;
  logic        oam_dma_wr;

  oam_dma_ctrl dut (
    .cclk         (cclk),
    .n_reset2     (n_reset2),
    .ff46_wr      (ff46_wr),
    .ff46_rd      (ff46_rd),
    .d_in         (d_in),
    .d_out        (d_out),
    .dma_din      (dma_din),
    .dma_pending  (dma_pending),
    .dma_run      (dma_run),
    .dma_a        (dma_a),
    .dma_a_hi     (dma_a_hi),
    .vram_to_oam  (vram_to_oam),
    .dma_addr_ext (dma_addr_ext),
    .oam_a        (oam_a),
    .oam_din      (oam_din),
    .oam_dma_wr   (oam_dma_wr)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transfer scenario. Cycle n is the interval after clock edge n; the FF46 write is
  // driven during cycle -1 so that edge 0 samples it.
  typedef struct {
    logic [7:0] s;        // first page written
    int         rs_at;    // cycle of a second FF46 write (-1: none)
    logic [7:0] rs_val;   // page of the second write
    int         rst_at;   // cycle at which reset is pulsed (-1: none)
    int         ncyc;     // cycles to observe
    int         pulses;   // expected oam_dma_wr pulses
    int         run_cnt;  // expected dma_run cycles
    int         first_run;
    int         last_run;
    int         pend;     // expected dma_pending cycles
    logic [2:0] hi;       // dma_a_hi when idle at the end
    logic       vram;     // vram_to_oam when idle at the end
  } vec_t;

  vec_t vecs[8];

  logic [44:0] all_out;
  assign all_out = {dma_pending, dma_run, dma_a, dma_a_hi, vram_to_oam, dma_addr_ext,
                    oam_a, oam_din, oam_dma_wr, d_out};

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] cur_s;
    logic [7:0] din_last;
    int exp_idx, exp_wr, pulses, run_cnt, first_run, last_run, pend;
    pulses = 0; run_cnt = 0; first_run = -1; last_run = -1; pend = 0;
    @(negedge cclk);
    ff46_wr = 1'b1;
    d_in    = v.s;
    cur_s   = v.s;
    exp_idx = 0;
    exp_wr  = 8;
    din_last = dma_din;
    for (int n = 0; n < v.ncyc; n++) begin
      @(negedge cclk);
      ff46_wr = 1'b0;
      if (dma_run) begin
        run_cnt++;
        if (first_run < 0) first_run = n;
        last_run = n;
      end
      if (dma_pending) pend++;
      if (oam_dma_wr) begin
        chk($sformatf("v%0d wr_cycle", idx), 64'(n), 64'(exp_wr));
        chk($sformatf("v%0d oam_a", idx), 64'(oam_a), 64'(exp_idx));
        chk($sformatf("v%0d dma_a", idx), 64'(dma_a), 64'({cur_s[4:0], 8'(exp_idx)}));
        chk($sformatf("v%0d oam_din", idx), 64'(oam_din), 64'(din_last));
        chk($sformatf("v%0d src_decode", idx),
            64'({dma_a_hi, vram_to_oam, dma_addr_ext, dma_run}),
            64'({cur_s[7:5], cur_s[7:5] == 3'b100, cur_s[7:5] != 3'b100, 1'b1}));
        pulses++;
        exp_idx++;
        exp_wr += 4;
      end
      if (n == 300) begin
        ff46_rd = 1'b1;
        #1 chk($sformatf("v%0d rd_midrun", idx), 64'(d_out), 64'(cur_s));
        ff46_rd = 1'b0;
        #1 chk($sformatf("v%0d rd_low", idx), 64'(d_out), 64'h0);
      end
      if (n == v.rs_at) begin
        ff46_wr = 1'b1;
        d_in    = v.rs_val;
        cur_s   = v.rs_val;
        exp_idx = 0;
        exp_wr  = n + 9;
      end
      if (n == v.rst_at) begin
        n_reset2 = 1'b0;
        #1 chk($sformatf("v%0d reset_outputs", idx), 64'(all_out), 64'h0);
        cur_s  = 8'h00;
        exp_wr = -1000;
      end
      if (v.rst_at >= 0 && n == v.rst_at + 3) n_reset2 = 1'b1;
      dma_din  = 8'(n * 29 + idx * 13 + 7);
      din_last = dma_din;
    end
    chk($sformatf("v%0d pulse_count", idx), 64'(pulses), 64'(v.pulses));
    chk($sformatf("v%0d run_cycles", idx), 64'(run_cnt), 64'(v.run_cnt));
    chk($sformatf("v%0d first_run", idx), 64'(first_run), 64'(v.first_run));
    chk($sformatf("v%0d last_run", idx), 64'(last_run), 64'(v.last_run));
    chk($sformatf("v%0d pending_cycles", idx), 64'(pend), 64'(v.pend));
    chk($sformatf("v%0d idle_decode", idx),
        64'({dma_a_hi, vram_to_oam, dma_addr_ext, dma_run, dma_pending, oam_dma_wr}),
        64'({v.hi, v.vram, 4'b0000}));
    ff46_rd = 1'b1;
    #1 chk($sformatf("v%0d rd_idle", idx), 64'(d_out), 64'(cur_s));
    ff46_rd = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hC1, -1,  8'h00, -1,  700,  160, 640,  5, 644,  4, 3'b110, 1'b0};
    vecs[1] = '{8'h80, -1,  8'h00, -1,  700,  160, 640,  5, 644,  4, 3'b100, 1'b1};
    vecs[2] = '{8'h9F, -1,  8'h00, -1,  700,  160, 640,  5, 644,  4, 3'b100, 1'b1};
    vecs[3] = '{8'hE0, -1,  8'h00, -1,  700,  160, 640,  5, 644,  4, 3'b111, 1'b0};
    // restart in XFER at byte 50: 50 + 160 pulses, dma_run continuous
    vecs[4] = '{8'hC0, 204, 8'hD0, -1,  900,  210, 845,  5, 849,  4, 3'b110, 1'b0};
    // restart during the start delay: delay begins again, pending the whole time
    vecs[5] = '{8'h55, 2,   8'h66, -1,  700,  160, 640,  8, 647,  7, 3'b011, 1'b0};
    // write during the last byte's write pulse: that byte is not repeated
    vecs[6] = '{8'h3A, 644, 8'h8F, -1,  1350, 320, 1280, 5, 1289, 8, 3'b100, 1'b1};
    // reset at byte 80: abort, nothing after release, page cleared
    vecs[7] = '{8'h3A, -1,  8'h00, 325, 700,  80,  321,  5, 325,  4, 3'b000, 1'b0};

    n_reset2 = 1'b0;
    ff46_wr  = 1'b0;
    ff46_rd  = 1'b0;
    d_in     = 8'h00;
    dma_din  = 8'h00;
    #3 chk("reset_outputs", 64'(all_out), 64'h0);
    ff46_rd = 1'b1;
    #1 chk("reset_readback", 64'(d_out), 64'h0);
    ff46_rd = 1'b0;
    @(negedge cclk);
    n_reset2 = 1'b1;
    repeat (2) @(negedge cclk);
    chk("idle_after_reset", 64'(all_out), 64'h0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
      repeat (3) @(negedge cclk);
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
